// File: rtl/operand_fetch_unit.sv
// Operand fetch front-end for a 2R/1W register file: busy scoreboard, write-back forwarding, one-entry output stage.
// Latency: request accepted at edge N gives operands in cycle N+1. req_ready drops on RAW hazard or a full, unconsumed output stage.
module operand_fetch_unit #(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 2,
   parameter int STALL_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic [ADDR_WIDTH-1:0]  req_src0,
   input  logic [ADDR_WIDTH-1:0]  req_src1,
   input  logic [ADDR_WIDTH-1:0]  req_dst,
   input  logic                   req_dst_en,
   input  logic                   wb_valid,
   input  logic [ADDR_WIDTH-1:0]  wb_register,
   input  logic [DATA_WIDTH-1:0]  wb_data,
   output logic [ADDR_WIDTH-1:0]  rf_read_register_port_0,
   output logic [ADDR_WIDTH-1:0]  rf_read_register_port_1,
   input  logic [DATA_WIDTH-1:0]  rf_read_data_port_0,
   input  logic [DATA_WIDTH-1:0]  rf_read_data_port_1,
   output logic [ADDR_WIDTH-1:0]  rf_write_register,
   output logic [DATA_WIDTH-1:0]  rf_write_data,
   output logic                   rf_write_enable,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [DATA_WIDTH-1:0]  rsp_op0,
   output logic [DATA_WIDTH-1:0]  rsp_op1,
   output logic [ADDR_WIDTH-1:0]  rsp_dst,
   output logic                   rsp_dst_en,
   output logic [STALL_WIDTH-1:0] stall_count
);

   localparam int NUM_REGS = 1 << ADDR_WIDTH;
   localparam logic [STALL_WIDTH-1:0] STALL_ONE = 1;

   logic [NUM_REGS-1:0]   busy;
   logic [NUM_REGS-1:0]   busy_nxt;
   logic                  fwd0, fwd1, haz0, haz1, out_space, issue;
   logic [DATA_WIDTH-1:0] op0, op1;

   assign rf_read_register_port_0 = req_src0;
   assign rf_read_register_port_1 = req_src1;
   assign rf_write_register       = wb_register;
   assign rf_write_data           = wb_data;
   assign rf_write_enable         = wb_valid;

   always_comb begin
      fwd0      = wb_valid && (wb_register == req_src0);
      fwd1      = wb_valid && (wb_register == req_src1);
      op0       = fwd0 ? wb_data : rf_read_data_port_0;
      op1       = fwd1 ? wb_data : rf_read_data_port_1;
      // A write-back landing this cycle resolves the hazard it would otherwise cause
      haz0      = busy[req_src0] && !fwd0;
      haz1      = busy[req_src1] && !fwd1;
      out_space = !rsp_valid || rsp_ready;
      req_ready = !haz0 && !haz1 && out_space;
      issue     = req_valid && req_ready;
      busy_nxt  = busy;
      if (wb_valid)
         busy_nxt[wb_register] = 1'b0;
      // Set after clear: a new pending write outranks a concurrent write-back
      if (issue && req_dst_en)
         busy_nxt[req_dst] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         busy        <= '0;
         rsp_valid   <= 1'b0;
         rsp_op0     <= '0;
         rsp_op1     <= '0;
         rsp_dst     <= '0;
         rsp_dst_en  <= 1'b0;
         stall_count <= '0;
      end else begin
         busy <= busy_nxt;
         if (issue) begin
            rsp_valid  <= 1'b1;
            rsp_op0    <= op0;
            rsp_op1    <= op1;
            rsp_dst    <= req_dst;
            rsp_dst_en <= req_dst_en;
         end else if (rsp_ready) begin
            rsp_valid  <= 1'b0;
         end
         if (req_valid && !req_ready && (stall_count != '1))
            stall_count <= stall_count + STALL_ONE;
      end
   end

endmodule

// File: tb/tb_operand_fetch_unit.sv
// Scoreboard bench for operand_fetch_unit: random and directed traffic against an abstract register/scoreboard model.
module tb_operand_fetch_unit;
   localparam int DW = 32;
   localparam int AW = 2;
   localparam int SW = 4;
   localparam int STALL_MAX = (1 << SW) - 1;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          req_valid = 1'b0, req_ready;
   logic [AW-1:0] req_src0 = '0, req_src1 = '0, req_dst = '0;
   logic          req_dst_en = 1'b0;
   logic          wb_valid = 1'b0;
   logic [AW-1:0] wb_register = '0;
   logic [DW-1:0] wb_data = '0;
   logic [AW-1:0] rf_read_register_port_0, rf_read_register_port_1, rf_write_register;
   logic [DW-1:0] rf_read_data_port_0, rf_read_data_port_1, rf_write_data;
   logic          rf_write_enable;
   logic          rsp_valid, rsp_ready = 1'b1;
   logic [DW-1:0] rsp_op0, rsp_op1;
   logic [AW-1:0] rsp_dst;
   logic          rsp_dst_en;
   logic [SW-1:0] stall_count;

   operand_fetch_unit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STALL_WIDTH(SW)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_src0(req_src0), .req_src1(req_src1), .req_dst(req_dst), .req_dst_en(req_dst_en),
      .wb_valid(wb_valid), .wb_register(wb_register), .wb_data(wb_data),
      .rf_read_register_port_0(rf_read_register_port_0), .rf_read_register_port_1(rf_read_register_port_1),
      .rf_read_data_port_0(rf_read_data_port_0), .rf_read_data_port_1(rf_read_data_port_1),
      .rf_write_register(rf_write_register), .rf_write_data(rf_write_data), .rf_write_enable(rf_write_enable),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_op0(rsp_op0), .rsp_op1(rsp_op1),
      .rsp_dst(rsp_dst), .rsp_dst_en(rsp_dst_en), .stall_count(stall_count)
   );

   always #5 clk = ~clk;

   // Register file as seen by the DUT, written only through the DUT's write port
   logic [DW-1:0] rf_mem [4] = '{default: '0};
   always @(posedge clk) if (rf_write_enable) rf_mem[rf_write_register] <= rf_write_data;
   assign rf_read_data_port_0 = rf_mem[rf_read_register_port_0];
   assign rf_read_data_port_1 = rf_mem[rf_read_register_port_1];

   typedef struct packed {
      logic [DW-1:0] op0;
      logic [DW-1:0] op1;
      logic [AW-1:0] dst;
      logic          dst_en;
   } rsp_t;
   rsp_t exp_q[$];

   // Reference model state
   logic [DW-1:0] ref_regs [4] = '{default: '0};
   bit            m_pending [4] = '{default: 1'b0};
   bit            m_full = 1'b0;
   int            m_stall = 0;
   int            checks = 0, errors = 0, issued = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock cycle: drive at negedge, check and advance the model mid-cycle
   task automatic cyc(input bit rv, input int s0, input int s1, input int d, input bit de,
                      input bit wv, input int wr, input logic [DW-1:0] wd, input bit rr, input bit rst);
      bit   f0, f1, exp_ready, iss;
      rsp_t e;
      @(negedge clk);
      reset = rst; req_valid = rv; req_src0 = AW'(s0); req_src1 = AW'(s1);
      req_dst = AW'(d); req_dst_en = de; wb_valid = wv; wb_register = AW'(wr);
      wb_data = wd; rsp_ready = rr;
      #2;
      f0 = wv && (wr == s0);
      f1 = wv && (wr == s1);
      exp_ready = !(m_pending[s0] && !f0) && !(m_pending[s1] && !f1) && (!m_full || rr);
      iss = rv && exp_ready && !rst;
      check("req_ready", {63'b0, req_ready}, {63'b0, exp_ready});
      check("rsp_valid", {63'b0, rsp_valid}, {63'b0, m_full});
      check("stall_count", 64'(stall_count), 64'(m_stall));
      check("rf_read_sel", {60'b0, rf_read_register_port_1, rf_read_register_port_0}, 64'(s1 * 4 + s0));
      check("rf_write", {rf_write_enable, rf_write_register, rf_write_data},
            {wv, AW'(wr), wd});
      if (rst) begin
         m_pending = '{default: 1'b0};
         m_full = 1'b0;
         m_stall = 0;
         exp_q.delete();
      end else begin
         if (iss) begin
            e.op0 = f0 ? wd : ref_regs[s0];
            e.op1 = f1 ? wd : ref_regs[s1];
            e.dst = AW'(d);
            e.dst_en = de;
            exp_q.push_back(e);
            issued++;
         end
         if (rv && !exp_ready && m_stall < STALL_MAX) m_stall++;
         m_full = iss || (m_full && !rr);
         if (wv) m_pending[wr] = 1'b0;
         if (iss && de) m_pending[d] = 1'b1;
      end
      if (wv) ref_regs[wr] = wd;
   endtask

   task automatic idle(input bit rr);
      cyc(0, 0, 0, 0, 0, 0, 0, '0, rr, 0);
   endtask

   // Monitor: a response is consumed at the edge that follows a high rsp_valid && rsp_ready
   initial begin
      rsp_t e;
      forever begin
         @(negedge clk);
         #3;
         if (!reset && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL rsp_unexpected: got op0=%0h with no response outstanding at %0t", rsp_op0, $time);
            end else begin
               e = exp_q.pop_front();
               check("rsp_op0", 64'(rsp_op0), 64'(e.op0));
               check("rsp_op1", 64'(rsp_op1), 64'(e.op1));
               check("rsp_dst", {62'b0, rsp_dst}, {62'b0, e.dst});
               check("rsp_dst_en", {63'b0, rsp_dst_en}, {63'b0, e.dst_en});
            end
         end
      end
   end

   initial begin
      int busy_list[$];
      int wr;
      // Reset then idle
      cyc(0, 0, 0, 0, 0, 0, 0, '0, 1, 1);
      cyc(0, 0, 0, 0, 0, 0, 0, '0, 1, 1);
      idle(1);
      // Back-to-back fetch after preloading r1/r2
      cyc(0, 0, 0, 0, 0, 1, 1, 32'h11111111, 1, 0);
      cyc(0, 0, 0, 0, 0, 1, 2, 32'h22222222, 1, 0);
      repeat (3) cyc(1, 1, 2, 0, 0, 0, 0, '0, 1, 0);
      idle(1);
      // RAW stall resolved by a forwarded write-back
      cyc(1, 0, 0, 3, 1, 0, 0, '0, 1, 0);
      repeat (4) cyc(1, 3, 1, 0, 0, 0, 0, '0, 1, 0);
      cyc(1, 3, 1, 0, 0, 1, 3, 32'hDEADBEEF, 1, 0);
      idle(1);
      // Set-wins collision on r2
      cyc(1, 0, 1, 2, 1, 0, 0, '0, 1, 0);
      cyc(1, 0, 1, 2, 1, 1, 2, 32'h0BADF00D, 1, 0);
      repeat (3) cyc(1, 2, 2, 0, 0, 0, 0, '0, 1, 0);
      cyc(1, 2, 2, 0, 0, 1, 2, 32'h12345678, 1, 0);
      idle(1);
      // Backpressure: output stage holds, pending request goes when the consumer returns
      cyc(1, 1, 2, 1, 0, 0, 0, '0, 0, 0);
      repeat (5) cyc(1, 2, 1, 3, 0, 0, 0, '0, 0, 0);
      cyc(1, 2, 1, 3, 0, 0, 0, '0, 1, 0);
      idle(1);
      // Stall counter saturation, then reset with a full output stage and busy bits set
      cyc(1, 1, 1, 0, 1, 0, 0, '0, 0, 0);
      repeat (20) cyc(1, 0, 0, 1, 0, 0, 0, '0, 0, 0);
      cyc(1, 0, 0, 1, 1, 0, 0, '0, 0, 1);
      cyc(1, 0, 0, 1, 0, 0, 0, '0, 1, 0);
      idle(1);
      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         busy_list.delete();
         for (int r = 0; r < 4; r++) if (m_pending[r]) busy_list.push_back(r);
         wr = (busy_list.size() != 0 && $urandom_range(0, 1) == 1) ?
              busy_list[$urandom_range(0, busy_list.size() - 1)] : int'($urandom_range(0, 3));
         cyc($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 3), $urandom_range(0, 1) == 1,
             $urandom_range(0, 2) == 0, wr, $urandom, $urandom_range(0, 3) != 0,
             $urandom_range(0, 299) == 0);
      end
      repeat (3) idle(1);
      check("queue_drained", 64'(exp_q.size()), 64'd0);
      check("issued_nonzero", 64'(issued > 100), 64'd1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
